// File: rtl/neurotile_sequencer_pkg.sv
// Shared opcodes and state encoding for the neurotile command path.
// Used by the pin decoder, the sequencer and the tile array.
package neurotile_pkg;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_CLEAR
    } state_e;

    // A zero step count requests the full 256-step run.
    function automatic logic [8:0] step_count(input logic [7:0] d);
        return (d == 8'd0) ? 9'd256 : {1'b0, d};
    endfunction

endpackage

// File: rtl/neurotile_sequencer_if.sv
// Command byte-stream handshake into the neurotile sequencer.
// The pin decoder is the master, the sequencer the slave.
interface neurotile_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/neurotile_sequencer_step_timer.sv
// Step pacing: 9-bit remaining-step down-counter plus inter-pulse gap counter.
// The first pulse leaves on the start edge; last_o flags gap expiry after the final one.
module neurotile_step_timer #(
    parameter int STEP_GAP = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [8:0] count_i,
    input  logic       ena_i,
    output logic       step_o,
    output logic       last_o
);

    localparam int GW = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
    localparam logic [GW-1:0] GAP_RELOAD = GW'(STEP_GAP - 1);

    logic [8:0]    rem_q;
    logic [GW-1:0] gap_q;
    logic          step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            gap_q  <= '0;
            step_q <= 1'b0;
        end else begin
            step_q <= 1'b0;
            if (start_i) begin
                step_q <= 1'b1;
                rem_q  <= count_i - 9'd1;
                gap_q  <= GAP_RELOAD;
            end else if (ena_i) begin
                if (gap_q != '0) begin
                    gap_q <= gap_q - 1'b1;
                end else if (rem_q != '0) begin
                    step_q <= 1'b1;
                    rem_q  <= rem_q - 9'd1;
                    gap_q  <= GAP_RELOAD;
                end
            end
        end
    end

    assign step_o = step_q;
    assign last_o = (gap_q == '0) && (rem_q == '0);

endmodule

// File: rtl/neurotile_sequencer.sv
// Command-driven controller: streams per-tile config bytes, then paces tile steps.
// Sole writer of tile configuration.
module neurotile_sequencer
    import neurotile_pkg::*;
#(
    parameter int N_TILES        = 4,
    parameter int WORDS_PER_TILE = 4,
    parameter int STEP_GAP       = 2,
    localparam int TW = $clog2(N_TILES),
    localparam int AW = $clog2(WORDS_PER_TILE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    neurotile_sequencer_if.slave  cmd,
    output logic                  cfg_we,
    output logic [TW-1:0]         cfg_tile,
    output logic [AW-1:0]         cfg_addr,
    output logic [7:0]            cfg_data,
    output logic                  tile_step,
    output logic                  tile_clear,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [TW-1:0] TILE_LAST = TW'(N_TILES - 1);
    localparam logic [AW-1:0] WORD_LAST = AW'(WORDS_PER_TILE - 1);

    state_e        state_q;
    logic [TW-1:0] tile_q;
    logic [AW-1:0] word_q;
    logic          loaded_q;
    logic          err_q;
    logic          cfg_we_q;
    logic [TW-1:0] cfg_tile_q;
    logic [AW-1:0] cfg_addr_q;
    logic [7:0]    cfg_data_q;
    logic          clear_q;
    logic          done_q;

    logic accept;
    logic run_start;
    logic timer_last;

    assign cmd.cmd_ready = ena & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign run_start     = accept & (state_q == ST_IDLE)
                         & (cmd.cmd_op == OP_RUN) & loaded_q;

    neurotile_step_timer #(
        .STEP_GAP (STEP_GAP)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (run_start),
        .count_i (step_count(cmd.cmd_data)),
        .ena_i   (ena & (state_q == ST_RUN)),
        .step_o  (tile_step),
        .last_o  (timer_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tile_q     <= '0;
            word_q     <= '0;
            loaded_q   <= 1'b0;
            err_q      <= 1'b0;
            cfg_we_q   <= 1'b0;
            cfg_tile_q <= '0;
            cfg_addr_q <= '0;
            cfg_data_q <= '0;
            clear_q    <= 1'b0;
            done_q     <= 1'b0;
        end else if (!ena) begin
            // Paused: hold everything, drop any strobes.
            cfg_we_q <= 1'b0;
            clear_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cfg_we_q <= 1'b0;
            clear_q  <= 1'b0;
            done_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        unique case (cmd.cmd_op)
                            OP_LOAD: begin
                                state_q  <= ST_LOAD;
                                tile_q   <= '0;
                                word_q   <= '0;
                                loaded_q <= 1'b0;
                            end
                            OP_RUN: begin
                                if (loaded_q) state_q <= ST_RUN;
                                else          err_q   <= 1'b1;
                            end
                            OP_CLEAR: begin
                                state_q  <= ST_CLEAR;
                                clear_q  <= 1'b1;
                                done_q   <= 1'b1;
                                loaded_q <= 1'b0;
                                err_q    <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        cfg_we_q   <= 1'b1;
                        cfg_tile_q <= tile_q;
                        cfg_addr_q <= word_q;
                        cfg_data_q <= cmd.cmd_data;
                        if (word_q == WORD_LAST) begin
                            word_q <= '0;
                            if (tile_q == TILE_LAST) begin
                                tile_q   <= '0;
                                loaded_q <= 1'b1;
                                done_q   <= 1'b1;
                                state_q  <= ST_IDLE;
                            end else begin
                                tile_q <= tile_q + 1'b1;
                            end
                        end else begin
                            word_q <= word_q + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (timer_last) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_CLEAR: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign cfg_we     = cfg_we_q;
    assign cfg_tile   = cfg_tile_q;
    assign cfg_addr   = cfg_addr_q;
    assign cfg_data   = cfg_data_q;
    assign tile_clear = clear_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_neurotile_sequencer.sv
// Directed bench for neurotile_sequencer: load table, step timing, pause and reset cases.
module tb_neurotile_sequencer;
    import neurotile_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b0;
    logic       cfg_we, tile_step, tile_clear, busy, done, err;
    logic [1:0] cfg_tile, cfg_addr;
    logic [7:0] cfg_data;

    neurotile_sequencer_if cmd_if ();

    neurotile_sequencer #(
        .N_TILES        (4),
        .WORDS_PER_TILE (4),
        .STEP_GAP       (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cmd        (cmd_if.slave),
        .cfg_we     (cfg_we),
        .cfg_tile   (cfg_tile),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .tile_step  (tile_step),
        .tile_clear (tile_clear),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] tile;
        logic [1:0] addr;
        logic       done;
        logic       busy;
    } ld_vec_t;

    typedef struct {
        logic step;
        logic done;
        logic busy;
    } run_vec_t;

    ld_vec_t  ld_tab [16];
    run_vec_t run_tab[8];

    int n_chk = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int step_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (cfg_we)    we_cnt++;
        if (tile_step) step_cnt++;
        if (done)      done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = d;
        tick();
    endtask

    task automatic do_load(input logic [7:0] base, input bit pause);
        int w0;
        int d0;
        logic [7:0] exp_d;
        w0 = we_cnt;
        d0 = done_cnt;
        send(OP_LOAD, 8'hAA);
        chk("load_hdr_busy", busy, 1);
        chk("load_hdr_no_write", cfg_we, 0);
        for (int i = 0; i < 16; i++) begin
            if (pause && i == 7) begin
                ena = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    chk("pause_ld_we", cfg_we, 0);
                    chk("pause_ld_ready", cmd_if.cmd_ready, 0);
                end
                ena = 1'b1;
            end
            exp_d = ld_tab[i].data + base;
            send(2'(i), exp_d);
            chk("ld_we", cfg_we, 1);
            chk("ld_tile", cfg_tile, ld_tab[i].tile);
            chk("ld_addr", cfg_addr, ld_tab[i].addr);
            chk("ld_data", cfg_data, exp_d);
            chk("ld_done", done, ld_tab[i].done);
            chk("ld_busy", busy, ld_tab[i].busy);
        end
        cmd_if.cmd_valid = 1'b0;
        tick();
        chk("ld_after_we", cfg_we, 0);
        chk("ld_after_done", done, 0);
        chk("ld_total_writes", we_cnt - w0, 16);
        chk("ld_total_done", done_cnt - d0, 1);
    endtask

    initial begin
        int s0;
        int d0;
        bit seen;

        for (int i = 0; i < 16; i++) begin
            ld_tab[i].data = 8'h10 + 8'(i);
            ld_tab[i].tile = 2'(i / 4);
            ld_tab[i].addr = 2'(i % 4);
            ld_tab[i].done = (i == 15);
            ld_tab[i].busy = (i != 15);
        end
        run_tab[0] = '{1'b1, 1'b0, 1'b1};
        run_tab[1] = '{1'b0, 1'b0, 1'b1};
        run_tab[2] = '{1'b1, 1'b0, 1'b1};
        run_tab[3] = '{1'b0, 1'b0, 1'b1};
        run_tab[4] = '{1'b1, 1'b0, 1'b1};
        run_tab[5] = '{1'b0, 1'b0, 1'b1};
        run_tab[6] = '{1'b0, 1'b1, 1'b0};
        run_tab[7] = '{1'b0, 1'b0, 1'b0};

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_NOP;
        cmd_if.cmd_data  = 8'h00;

        #3;
        chk("rst_we", cfg_we, 0);
        chk("rst_step", tile_step, 0);
        chk("rst_clear", tile_clear, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready_ena0", cmd_if.cmd_ready, 0);
        rst_n = 1'b1;
        ena   = 1'b1;
        #1;
        chk("ready_ena1", cmd_if.cmd_ready, 1);
        tick();

        send(OP_NOP, 8'h55);
        cmd_if.cmd_valid = 1'b0;
        chk("nop_busy", busy, 0);
        chk("nop_done", done, 0);

        // RUN with nothing loaded, then CLEAR
        s0 = step_cnt;
        d0 = done_cnt;
        send(OP_RUN, 8'd5);
        cmd_if.cmd_valid = 1'b0;
        chk("unloaded_run_err", err, 1);
        chk("unloaded_run_busy", busy, 0);
        repeat (4) tick();
        chk("unloaded_run_steps", step_cnt - s0, 0);
        chk("unloaded_run_done", done_cnt - d0, 0);
        send(OP_CLEAR, 8'h00);
        cmd_if.cmd_valid = 1'b0;
        chk("clear_pulse", tile_clear, 1);
        chk("clear_done", done, 1);
        chk("clear_err", err, 0);
        chk("clear_busy", busy, 1);
        tick();
        chk("clear_pulse_end", tile_clear, 0);
        chk("clear_busy_end", busy, 0);

        do_load(8'h00, 1'b0);

        // RUN 3: steps at +1,+3,+5, done at +7
        s0 = step_cnt;
        send(OP_RUN, 8'd3);
        cmd_if.cmd_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            chk("run3_step", tile_step, run_tab[k].step);
            chk("run3_done", done, run_tab[k].done);
            chk("run3_busy", busy, run_tab[k].busy);
            if (k == 1) chk("run3_ready", cmd_if.cmd_ready, 0);
        end
        chk("run3_total", step_cnt - s0, 3);
        chk("run3_err", err, 0);

        // RUN 0 means 256 steps
        s0 = step_cnt;
        send(OP_RUN, 8'd0);
        cmd_if.cmd_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 700 && !seen; c++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("run0_done_seen", seen, 1);
        chk("run0_steps", step_cnt - s0, 256);
        tick();

        do_load(8'h10, 1'b1);

        // RUN 3 paused after step 2
        s0 = step_cnt;
        d0 = done_cnt;
        send(OP_RUN, 8'd3);
        cmd_if.cmd_valid = 1'b0;
        tick();
        tick();
        chk("runp_step2", tile_step, 1);
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("runp_pause_step", tile_step, 0);
            chk("runp_pause_done", done, 0);
            chk("runp_pause_busy", busy, 1);
        end
        ena = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("runp_done_seen", seen, 1);
        chk("runp_steps", step_cnt - s0, 3);
        tick();
        chk("runp_done_total", done_cnt - d0, 1);

        // Reset during LOAD beat 9
        send(OP_LOAD, 8'h00);
        for (int i = 0; i < 9; i++) send(OP_NOP, 8'h40 + 8'(i));
        chk("prerst_we", cfg_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", cfg_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", cfg_data, 0);
        chk("midrst_done", done, 0);
        cmd_if.cmd_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        s0 = step_cnt;
        d0 = done_cnt;
        send(OP_RUN, 8'd2);
        cmd_if.cmd_valid = 1'b0;
        chk("postrst_run_err", err, 1);
        chk("postrst_run_busy", busy, 0);
        repeat (6) tick();
        chk("postrst_steps", step_cnt - s0, 0);
        chk("postrst_done", done_cnt - d0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
